// File: rtl/sr_pq_if.sv
// rtl/sr_pq_if.sv - enqueue/dequeue bundle between a queue user and sr_pq
//
// Purpose: carries one priority-queue request per clock and the queue status.
// Ports (signals):
//   enq, deq  request strobes, sampled at the rising edge
//   kvi       {key,val} entry to enqueue
//   kvo       head entry (smallest key), registered
//   empty     no valid entries
//   full      DEPTH valid entries
//   count     number of valid entries
//   err       one-cycle pulse after a dropped request
// Modports: master drives requests, slave is the queue.
interface sr_pq_if #(
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 4,
  parameter int DEPTH     = 8
);
  localparam int KVW = KEY_WIDTH + VAL_WIDTH;
  localparam int CW  = $clog2(DEPTH + 1);

  logic           enq;
  logic           deq;
  logic [KVW-1:0] kvi;
  logic [KVW-1:0] kvo;
  logic           empty;
  logic           full;
  logic [CW-1:0]  count;
  logic           err;

  modport master (
    output enq, deq, kvi,
    input  kvo, empty, full, count, err
  );

  modport slave (
    input  enq, deq, kvi,
    output kvo, empty, full, count, err
  );
endinterface

// File: rtl/sr_pq.sv
// rtl/sr_pq.sv - shift-register priority queue, head is always the smallest key
//
// Purpose: keeps up to DEPTH {key,val} entries sorted in a linear array of
// registered cells; accepts an enqueue, a dequeue, or both every clock.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous assert, active-low reset (release synchronously upstream)
//   pq   sr_pq_if.slave: enq/deq/kvi in; kvo/empty/full/count/err out
module sr_pq #(
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 4,
  parameter int DEPTH     = 8
) (
  input logic    clk,
  input logic    rst,
  sr_pq_if.slave pq
);
  localparam int KVW = KEY_WIDTH + VAL_WIDTH;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [KVW-1:0]       kv_q [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [CW-1:0]        count_q;
  logic                 err_q;

  logic [KVW-1:0]       kv_d [DEPTH];
  logic [DEPTH-1:0]     vld_d;

  logic [KEY_WIDTH-1:0] new_key;
  // le[i]: cell i is valid and its key is <= the new key. Because the array is
  // sorted, le is a contiguous prefix; le[DEPTH] is a constant 0 sentinel.
  logic [DEPTH:0]       le;
  logic                 is_empty;
  logic                 is_full;
  logic                 do_ins;
  logic                 do_rep;
  logic                 do_pop;
  logic                 drop;

  assign new_key  = pq.kvi[KVW-1 -: KEY_WIDTH];
  assign is_empty = !vld_q[0];
  assign is_full  = vld_q[DEPTH-1];

  // enq+deq on an empty queue degrades to a plain insert.
  assign do_ins = pq.enq && !is_full && (!pq.deq || is_empty);
  assign do_rep = pq.enq && pq.deq && !is_empty;
  assign do_pop = pq.deq && !pq.enq && !is_empty;
  assign drop   = (pq.enq && !pq.deq && is_full) || (pq.deq && !pq.enq && is_empty);

  always_comb begin
    le = '0;
    for (int i = 0; i < DEPTH; i++) begin
      le[i] = vld_q[i] && (kv_q[i][KVW-1 -: KEY_WIDTH] <= new_key);
    end
  end

  // Each cell decides its next value from its own compare bit and its
  // neighbours' only, so timing does not grow with DEPTH.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    localparam bit FIRST = (i == 0);

    logic [KVW-1:0] prev_kv;
    logic           prev_le;
    logic           prev_vld;
    logic [KVW-1:0] next_kv;
    logic           next_vld;
    logic [KVW-1:0] kv_n;
    logic           vld_n;

    if (i == 0) begin : g_head
      // Cell 0 sees a virtual "always <= and valid" predecessor so the new
      // entry lands here when every stored key is larger.
      assign prev_kv  = '0;
      assign prev_le  = 1'b1;
      assign prev_vld = 1'b1;
    end else begin : g_body
      assign prev_kv  = kv_q[i-1];
      assign prev_le  = le[i-1];
      assign prev_vld = vld_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      // Shifting toward the head pulls in a zeroed, invalid entry.
      assign next_kv  = '0;
      assign next_vld = 1'b0;
    end else begin : g_inner
      assign next_kv  = kv_q[i+1];
      assign next_vld = vld_q[i+1];
    end

    always_comb begin
      kv_n  = kv_q[i];
      vld_n = vld_q[i];
      if (do_ins) begin
        // Cells past the insert point shift away from the head by one.
        vld_n = vld_q[i] | prev_vld;
        if (!le[i]) begin
          kv_n = prev_le ? pq.kvi : prev_kv;
        end
      end else if (do_rep) begin
        // Head leaves: cells before the insert point (counted from cell 1)
        // shift toward the head, the insert cell takes kvi, the rest hold.
        if (le[i+1]) begin
          kv_n = next_kv;
        end else if (FIRST || le[i]) begin
          kv_n = pq.kvi;
        end
      end else if (do_pop) begin
        kv_n  = next_kv;
        vld_n = next_vld;
      end
    end

    assign kv_d[i]  = kv_n;
    assign vld_d[i] = vld_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        kv_q[i] <= '0;
      end
      vld_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        kv_q[i] <= kv_d[i];
      end
      vld_q <= vld_d;
      err_q <= drop;
      if (do_ins) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign pq.kvo   = kv_q[0];
  assign pq.empty = is_empty;
  assign pq.full  = is_full;
  assign pq.count = count_q;
  assign pq.err   = err_q;
endmodule
